// File: rtl/neuron_mac_pipe.sv
// Time-multiplexed neuron: N_IN weight*pixel products over LANES multipliers,
// bias accumulate, optional ReLU, signed saturation, valid/ready on both sides.
module neuron_mac_pipe #(
  parameter int N_IN       = 32,
  parameter int LANES      = 8,
  parameter int WGT_W      = 19,
  parameter int PIX_W      = 10,
  parameter int FRAC_SHIFT = 3,
  parameter int OUT_W      = 26
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WGT_W-1:0]   in_wgt,
  input  logic [N_IN*PIX_W-1:0]   in_pix,
  input  logic [OUT_W-1:0]        bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    sat_flag
);

  localparam int P      = N_IN / LANES;
  localparam int PROD_W = WGT_W + PIX_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(N_IN) + 1;
  localparam int KW     = (P > 1) ? $clog2(P + 1) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(P);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (LANES < 1 || N_IN % LANES != 0) begin : g_bad_cfg
    $error("N_IN must be a positive multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

  state_t state, state_n;

  logic        [WGT_W-1:0]  wgt_q [N_IN];
  logic        [PIX_W-1:0]  pix_q [N_IN];
  logic                     relu_q;
  logic        [KW-1:0]     k;
  logic signed [PROD_W-1:0] prod   [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [ACC_W-1:0]  lsum, sum_d;
  logic signed [ACC_W-1:0]  acc, total;
  logic        [OUT_W-1:0]  res;
  logic                     sat;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (in_valid)     state_n = MAC;
      MAC:   if (k == K_LAST)  state_n = FINAL;
      FINAL:                   state_n = DONE;
      DONE:  if (out_ready)    state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Lane l of pass k takes element k*LANES+l; the drain cycle (k==P) reuses pass 0.
  always_comb begin
    int base;
    logic signed [PROD_W-1:0] w_ext, p_ext, full;
    base = (k < K_LAST) ? int'(k) * LANES : 0;
    for (int l = 0; l < LANES; l++) begin
      w_ext = {{(PROD_W-WGT_W){wgt_q[base+l][WGT_W-1]}}, wgt_q[base+l]};
      p_ext = {{(PROD_W-PIX_W){1'b0}}, pix_q[base+l]};
      full  = w_ext * p_ext;
      prod_d[l] = full >>> FRAC_SHIFT;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int l = 0; l < LANES; l++)
      sum_d = sum_d + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
  end

  // ReLU wins over saturation, so a clamped-to-zero result never flags.
  always_comb begin
    total = acc + lsum;
    res   = total[OUT_W-1:0];
    sat   = 1'b0;
    if (relu_q && total[ACC_W-1]) begin
      res = '0;
    end else if (total > MAXV) begin
      res = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (total < MINV) begin
      res = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < N_IN; i++) begin
        wgt_q[i] <= '0;
        pix_q[i] <= '0;
      end
      for (int l = 0; l < LANES; l++) prod[l] <= '0;
      relu_q   <= 1'b0;
      k        <= '0;
      lsum     <= '0;
      acc      <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < N_IN; i++) begin
            wgt_q[i] <= in_wgt[i*WGT_W +: WGT_W];
            pix_q[i] <= in_pix[i*PIX_W +: PIX_W];
          end
          for (int l = 0; l < LANES; l++) prod[l] <= '0;
          relu_q <= relu_en;
          k      <= '0;
          lsum   <= '0;
          acc    <= {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
        end
        MAC: begin
          if (k < K_LAST)
            for (int l = 0; l < LANES; l++) prod[l] <= prod_d[l];
          lsum <= sum_d;
          acc  <= acc + lsum;
          k    <= k + KW'(1);
        end
        FINAL: begin
          out_data <= res;
          sat_flag <= sat;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
